// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_scan_decoder_if                                                        |
// | Multiplexed seven-segment display bus plus the decoder's readback signals. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface seg_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [7:0]          seg_i;
    logic [DIGITS-1:0]   an_i;
    logic [4*DIGITS-1:0] val_o;
    logic [DIGITS-1:0]   dpo_o;
    logic [DIGITS-1:0]   err_o;
    logic                upd_o;
    logic                valid_o;

    // The display driver side owns the bus and observes the decoded result.
    modport master (
        output seg_i, an_i,
        input  val_o, dpo_o, err_o, upd_o, valid_o
    );

    modport slave (
        input  seg_i, an_i,
        output val_o, dpo_o, err_o, upd_o, valid_o
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_scan_decoder                                                           |
// | Passive observer that reconstructs digit codes from a scanned 7-seg bus.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    seg_scan_decoder_if.slave  bus
);

    localparam int         SW     = DIGITS + 8;
    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [SW-1:0]       smp_q,  smp_d;
    logic [3:0]          cnt_q,  cnt_d;
    logic [4*DIGITS-1:0] val_q,  val_d;
    logic [DIGITS-1:0]   dpo_q,  dpo_d;
    logic [DIGITS-1:0]   err_q,  err_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                upd_q,  upd_d;
    logic                valid_q;

    logic [DIGITS-1:0]   an_low;
    logic                onehot;
    logic                differs;
    logic                commit;
    logic                dec_ok;
    logic [3:0]          dec_code;

    // Inverse of the active-low segment encoding; blank maps to F.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b1111111: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    always_comb begin
        an_low   = ~bus.an_i;
        onehot   = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
        smp_d    = {bus.an_i, bus.seg_i};
        differs  = (smp_d != smp_q);
        {dec_ok, dec_code} = decode_seg(bus.seg_i[6:0]);
    end

    // Commit fires exactly once per run, on the edge the count reaches STABLE.
    always_comb begin
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (!onehot) begin
            cnt_d = 4'd0;
        end else if (differs) begin
            cnt_d  = 4'd1;
            commit = (STABLE == 4'd1);
        end else if (cnt_q < STABLE) begin
            cnt_d  = cnt_q + 4'd1;
            commit = ((cnt_q + 4'd1) == STABLE);
        end
    end

    always_comb begin
        val_d  = val_q;
        dpo_d  = dpo_q;
        err_d  = err_q;
        seen_d = seen_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (commit && an_low[k]) begin
                if (dec_ok) begin
                    val_d[4*k +: 4] = dec_code;
                end
                err_d[k]  = ~dec_ok;
                dpo_d[k]  = ~bus.seg_i[7];
                seen_d[k] = seen_q[k] | dec_ok;
            end
        end
        upd_d = commit && ({val_d, dpo_d, err_d} != {val_q, dpo_q, err_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q   <= '1;
            cnt_q   <= 4'd0;
            val_q   <= '1;
            dpo_q   <= '0;
            err_q   <= '0;
            seen_q  <= '0;
            upd_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            smp_q   <= smp_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            dpo_q   <= dpo_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            upd_q   <= upd_d;
            valid_q <= &seen_q;
        end
    end

    assign bus.val_o   = val_q;
    assign bus.dpo_o   = dpo_q;
    assign bus.err_o   = err_q;
    assign bus.upd_o   = upd_q;
    assign bus.valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg_scan_decoder                                                        |
// | Directed vectors with hand-computed readback values.                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_seg_scan_decoder;

    localparam int DIGITS        = 4;
    localparam int STABLE_CYCLES = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   upd_cnt;

    seg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_decoder #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold a bus value for n edges, sampling 1 time unit after each edge.
    task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
        for (int i = 0; i < n; i++) begin
            bus.an_i  = an;
            bus.seg_i = seg;
            @(posedge clk);
            #1;
            if (bus.upd_o === 1'b1) upd_cnt++;
        end
    endtask

    logic [3:0]  scan_an  [4];
    logic [7:0]  scan_seg [4];
    logic [15:0] scan_val [4];

    initial begin
        checks   = 0;
        failures = 0;
        upd_cnt  = 0;
        scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        scan_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        scan_val = '{16'hFFF0, 16'hFF10, 16'hF210, 16'h3210};

        rst_n     = 1'b0;
        bus.an_i  = 4'b1111;
        bus.seg_i = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_val",   32'(bus.val_o),   32'hFFFF);
        check("rst_valid", 32'(bus.valid_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, 8'hFF, 10);
        check("idle_val",   32'(bus.val_o),   32'hFFFF);
        check("idle_dpo",   32'(bus.dpo_o),   32'h0);
        check("idle_err",   32'(bus.err_o),   32'h0);
        check("idle_upd",   32'(upd_cnt),     32'h0);
        check("idle_valid", 32'(bus.valid_o), 32'h0);

        // Full scan: commit on 4th edge of each 6-cycle strobe.
        upd_cnt = 0;
        for (int d = 0; d < 4; d++) begin
            drive(scan_an[d], scan_seg[d], 3);
            check("scan_pre", 32'(bus.val_o), (d == 0) ? 32'hFFFF : 32'(scan_val[d-1]));
            drive(scan_an[d], scan_seg[d], 1);
            check("scan_val", 32'(bus.val_o), 32'(scan_val[d]));
            check("scan_upd", 32'(bus.upd_o), 32'h1);
            if (d == 3) check("valid_early", 32'(bus.valid_o), 32'h0);
            drive(scan_an[d], scan_seg[d], 1);
            check("scan_upd_w", 32'(bus.upd_o), 32'h0);
            if (d == 3) check("valid_rise", 32'(bus.valid_o), 32'h1);
            drive(scan_an[d], scan_seg[d], 1);
        end
        check("scan_upd_cnt", 32'(upd_cnt), 32'h4);

        // Decimal point, then an unrecognised pattern on digit 0.
        drive(4'b1110, 8'h40, 5);
        check("dp_dpo", 32'(bus.dpo_o), 32'h1);
        check("dp_val", 32'(bus.val_o), 32'h3210);
        drive(4'b1110, 8'hFE, 3);
        upd_cnt = 0;
        drive(4'b1110, 8'hFE, 1);
        check("bad_err", 32'(bus.err_o), 32'h1);
        check("bad_val", 32'(bus.val_o), 32'h3210);
        check("bad_dpo", 32'(bus.dpo_o), 32'h0);
        check("bad_upd", 32'(bus.upd_o), 32'h1);
        drive(4'b1110, 8'hFE, 1);

        // Glitch rejection on digit 1.
        upd_cnt = 0;
        drive(4'b1101, 8'h99, 3);
        drive(4'b1101, 8'h92, 1);
        drive(4'b1101, 8'h99, 3);
        check("gl_hold", 32'(bus.val_o), 32'h3210);
        check("gl_noupd", 32'(upd_cnt), 32'h0);
        drive(4'b1101, 8'h99, 1);
        check("gl_val", 32'(bus.val_o), 32'h3240);
        check("gl_upd", 32'(bus.upd_o), 32'h1);
        check("gl_err", 32'(bus.err_o), 32'h1);

        // Invalid AN never commits; identical re-commit gives no pulse.
        upd_cnt = 0;
        drive(4'b1100, 8'h99, 8);
        check("inv_upd", 32'(upd_cnt), 32'h0);
        check("inv_val", 32'(bus.val_o), 32'h3240);
        drive(4'b1101, 8'h99, 6);
        check("same_upd", 32'(upd_cnt), 32'h0);
        check("same_val", 32'(bus.val_o), 32'h3240);
        check("same_valid", 32'(bus.valid_o), 32'h1);

        // Reset mid-run at cnt=3, then four fresh edges to commit.
        drive(4'b1011, 8'hF9, 3);
        rst_n = 1'b0;
        #2;
        check("mr_val",   32'(bus.val_o),   32'hFFFF);
        check("mr_err",   32'(bus.err_o),   32'h0);
        check("mr_dpo",   32'(bus.dpo_o),   32'h0);
        check("mr_valid", 32'(bus.valid_o), 32'h0);
        check("mr_upd",   32'(bus.upd_o),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        upd_cnt = 0;
        drive(4'b1011, 8'hF9, 3);
        check("mr_pre", 32'(bus.val_o), 32'hFFFF);
        check("mr_pre_upd", 32'(upd_cnt), 32'h0);
        drive(4'b1011, 8'hF9, 1);
        check("mr_commit", 32'(bus.val_o), 32'hF1FF);
        check("mr_commit_upd", 32'(bus.upd_o), 32'h1);
        drive(4'b1011, 8'hF9, 2);
        check("mr_valid_low", 32'(bus.valid_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
